// File: rtl/lock_code_driver.sv
// Serial code-entry front end for the combinational encrypted_lock checker:
// assembles a 6-bit code, presents it on a..f, samples z and enforces a retry lockout.
module lock_code_driver #(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  input  logic       clear,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  input  logic       z,
  output logic       unlocked,
  output logic       fail,
  output logic       locked_out,
  output logic [1:0] tries_left
);

  localparam int unsigned CODE_W  = 6;
  localparam int unsigned SHIFT_W = CODE_W - 1;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned FAIL_W  = 2;
  localparam int unsigned TMR_MAX = (LOCKOUT_CYCLES > HOLD_CYCLES) ? LOCKOUT_CYCLES : HOLD_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_PRESENT,
    ST_CHECK,
    ST_OPEN,
    ST_LOCKOUT
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SHIFT_W-1:0]  shift_q, shift_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [FAIL_W-1:0]   fail_cnt_q, fail_cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic                bit_ready_q, bit_ready_d;
  logic                unlocked_q, unlocked_d;
  logic                fail_q, fail_d;
  logic                locked_out_q, locked_out_d;
  logic [1:0]          tries_q, tries_d;
  logic                limit_hit;

  // The shift register only needs the first five bits; the sixth goes straight to a..f.
  assign limit_hit = (32'(fail_cnt_q) + 32'd1) >= MAX_TRIES;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    code_d       = code_q;
    fail_cnt_d   = fail_cnt_q;
    tmr_d        = tmr_q;
    bit_ready_d  = bit_ready_q;
    unlocked_d   = unlocked_q;
    fail_d       = 1'b0;
    locked_out_d = locked_out_q;
    tries_d      = tries_q;

    case (state_q)
      ST_COLLECT: begin
        if (clear) begin
          cnt_d   = '0;
          shift_d = '0;
        end else if (bit_valid && bit_ready_q) begin
          if (cnt_q == CNT_W'(CODE_W - 1)) begin
            code_d      = {shift_q, bit_in};
            cnt_d       = '0;
            shift_d     = '0;
            bit_ready_d = 1'b0;
            state_d     = ST_PRESENT;
          end else begin
            shift_d = {shift_q[SHIFT_W-2:0], bit_in};
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end

      ST_PRESENT: state_d = ST_CHECK;

      ST_CHECK: begin
        if (z) begin
          state_d    = ST_OPEN;
          unlocked_d = 1'b1;
          fail_cnt_d = '0;
          tries_d    = 2'(MAX_TRIES);
          tmr_d      = TMR_W'(HOLD_CYCLES - 1);
        end else if (limit_hit) begin
          state_d      = ST_LOCKOUT;
          fail_d       = 1'b1;
          locked_out_d = 1'b1;
          fail_cnt_d   = fail_cnt_q + FAIL_W'(1);
          tries_d      = 2'd0;
          tmr_d        = TMR_W'(LOCKOUT_CYCLES - 1);
        end else begin
          state_d     = ST_COLLECT;
          fail_d      = 1'b1;
          fail_cnt_d  = fail_cnt_q + FAIL_W'(1);
          tries_d     = 2'(MAX_TRIES - 32'(fail_cnt_q) - 32'd1);
          bit_ready_d = 1'b1;
          code_d      = '0;
        end
      end

      ST_OPEN: begin
        if (tmr_q == '0) begin
          state_d     = ST_COLLECT;
          unlocked_d  = 1'b0;
          bit_ready_d = 1'b1;
          code_d      = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      ST_LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d      = ST_COLLECT;
          locked_out_d = 1'b0;
          fail_cnt_d   = '0;
          tries_d      = 2'(MAX_TRIES);
          bit_ready_d  = 1'b1;
          code_d       = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end

      default: begin
        state_d     = ST_COLLECT;
        bit_ready_d = 1'b1;
        code_d      = '0;
        cnt_d       = '0;
        shift_d     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_COLLECT;
      cnt_q        <= '0;
      shift_q      <= '0;
      code_q       <= '0;
      fail_cnt_q   <= '0;
      tmr_q        <= '0;
      bit_ready_q  <= 1'b1;
      unlocked_q   <= 1'b0;
      fail_q       <= 1'b0;
      locked_out_q <= 1'b0;
      tries_q      <= 2'(MAX_TRIES);
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      code_q       <= code_d;
      fail_cnt_q   <= fail_cnt_d;
      tmr_q        <= tmr_d;
      bit_ready_q  <= bit_ready_d;
      unlocked_q   <= unlocked_d;
      fail_q       <= fail_d;
      locked_out_q <= locked_out_d;
      tries_q      <= tries_d;
    end
  end

  assign {a, b, c, d, e, f} = code_q;
  assign bit_ready  = bit_ready_q;
  assign unlocked   = unlocked_q;
  assign fail       = fail_q;
  assign locked_out = locked_out_q;
  assign tries_left = tries_q;

endmodule

// File: tb/tb_lock_code_driver.sv
// Bench for lock_code_driver: models the lock with key 101011 and predicts
// each attempt's outcome from a simple failure counter.
module tb_lock_code_driver;

  localparam int unsigned MAX_TRIES      = 3;
  localparam int unsigned LOCKOUT_CYCLES = 16;
  localparam int unsigned HOLD_CYCLES    = 4;
  localparam logic [5:0]  KEY            = 6'b101011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       clear = 1'b0;
  logic       bit_ready, a, b, c, d, e, f, z, unlocked, fail, locked_out;
  logic [1:0] tries_left;

  int n_checks = 0;
  int n_fail   = 0;
  int m_fails  = 0;

  always #5 clk = ~clk;

  assign z = ({a, b, c, d, e, f} == KEY);

  lock_code_driver #(
    .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .clear(clear), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .z(z),
    .unlocked(unlocked), .fail(fail), .locked_out(locked_out), .tries_left(tries_left)
  );

  function automatic logic [5:0] st();
    return {bit_ready, unlocked, fail, locked_out, tries_left};
  endfunction

  function automatic logic [5:0] exp_st(bit br, bit ul, bit fl, bit lo, int tl);
    return {br, ul, fl, lo, 2'(tl)};
  endfunction

  function automatic logic [5:0] code_out();
    return {a, b, c, d, e, f};
  endfunction

  function automatic logic [5:0] wrong_code();
    logic [5:0] cd;
    cd = 6'($urandom);
    if (cd == KEY) cd = ~KEY;
    return cd;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers six bits MSB first, optionally with random idle gaps; returns at T+1.
  task automatic send_code(input logic [5:0] code, input bit gaps);
    int g;
    for (int i = 0; i < 6; i++) begin
      if (gaps) begin
        g = int'($urandom_range(0, 2));
        repeat (g) begin
          bit_valid = 1'b0;
          bit_in    = 1'($urandom);
          tick();
        end
      end
      bit_valid = 1'b1;
      bit_in    = code[5-i];
      n_checks++;
      if (bit_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL bit_ready_collect: got %b want 1 (bit %0d)", bit_ready, i);
      end
      tick();
    end
    bit_valid = 1'b0;
  endtask

  // Starting at T+1, follows the attempt through to the first cycle bits are accepted again.
  task automatic check_attempt(input logic [5:0] code);
    n_checks++;
    if (code_out() !== code || bit_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL present: code %b want %b, bit_ready %b want 0", code_out(), code, bit_ready);
    end
    tick();
    n_checks++;
    if (st() !== exp_st(0, 0, 0, 0, int'(MAX_TRIES) - m_fails)) begin
      n_fail++;
      $display("FAIL check_cycle: status %b want %b", st(), exp_st(0, 0, 0, 0, int'(MAX_TRIES) - m_fails));
    end
    tick();
    if (code == KEY) begin
      m_fails = 0;
      for (int k = 0; k < int'(HOLD_CYCLES); k++) begin
        n_checks++;
        if (st() !== exp_st(0, 1, 0, 0, MAX_TRIES)) begin
          n_fail++;
          $display("FAIL open_hold: cycle %0d status %b want %b", k, st(), exp_st(0, 1, 0, 0, MAX_TRIES));
        end
        tick();
      end
      n_checks++;
      if (st() !== exp_st(1, 0, 0, 0, MAX_TRIES) || code_out() !== 6'd0) begin
        n_fail++;
        $display("FAIL open_exit: status %b want %b, code %b want 000000", st(), exp_st(1, 0, 0, 0, MAX_TRIES), code_out());
      end
    end else if (m_fails + 1 < int'(MAX_TRIES)) begin
      m_fails++;
      n_checks++;
      if (st() !== exp_st(1, 0, 1, 0, int'(MAX_TRIES) - m_fails) || code_out() !== 6'd0) begin
        n_fail++;
        $display("FAIL mismatch: status %b want %b, code %b want 000000", st(), exp_st(1, 0, 1, 0, int'(MAX_TRIES) - m_fails), code_out());
      end
    end else begin
      n_checks++;
      if (st() !== exp_st(0, 0, 1, 1, 0)) begin
        n_fail++;
        $display("FAIL lockout_entry: status %b want %b", st(), exp_st(0, 0, 1, 1, 0));
      end
      for (int k = 0; k < int'(LOCKOUT_CYCLES); k++) begin
        bit_valid = 1'b1;
        bit_in    = 1'($urandom);
        if (k > 0) begin
          n_checks++;
          if (st() !== exp_st(0, 0, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL lockout_hold: cycle %0d status %b want %b", k, st(), exp_st(0, 0, 0, 1, 0));
          end
        end
        tick();
      end
      bit_valid = 1'b0;
      m_fails   = 0;
      n_checks++;
      if (st() !== exp_st(1, 0, 0, 0, MAX_TRIES) || code_out() !== 6'd0) begin
        n_fail++;
        $display("FAIL lockout_exit: status %b want %b, code %b", st(), exp_st(1, 0, 0, 0, MAX_TRIES), code_out());
      end
    end
  endtask

  task automatic check_reset_values(input string name);
    n_checks++;
    if (st() !== exp_st(1, 0, 0, 0, MAX_TRIES) || code_out() !== 6'd0) begin
      n_fail++;
      $display("FAIL %s: status %b want %b, code %b want 000000", name, st(), exp_st(1, 0, 0, 0, MAX_TRIES), code_out());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    m_fails = 0;
    check_reset_values("reset_state");
  endtask

  task automatic test_correct();
    send_code(KEY, 1'b0);
    check_attempt(KEY);
  endtask

  task automatic test_lockout();
    send_code(6'b001010, 1'b0);
    check_attempt(6'b001010);
    send_code(6'b101010, 1'b0);
    check_attempt(6'b101010);
    send_code(6'b011010, 1'b0);
    check_attempt(6'b011010);
    send_code(KEY, 1'b0);
    check_attempt(KEY);
  endtask

  task automatic test_single_mismatch();
    send_code(6'b001010, 1'b0);
    check_attempt(6'b001010);
    tick();
    n_checks++;
    if (st() !== exp_st(1, 0, 0, 0, 2)) begin
      n_fail++;
      $display("FAIL fail_pulse_width: status %b want %b", st(), exp_st(1, 0, 0, 0, 2));
    end
    send_code(KEY, 1'b1);
    check_attempt(KEY);
  endtask

  task automatic test_success_resets();
    logic [5:0] w;
    for (int i = 0; i < 2; i++) begin
      w = wrong_code();
      send_code(w, 1'b1);
      check_attempt(w);
    end
    n_checks++;
    if (tries_left !== 2'd1) begin
      n_fail++;
      $display("FAIL tries_after_two: got %0d want 1", tries_left);
    end
    send_code(KEY, 1'b0);
    check_attempt(KEY);
  endtask

  task automatic test_clear();
    logic [2:0] part;
    part = 3'b101;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      bit_in    = part[2-i];
      tick();
    end
    clear  = 1'b1;
    bit_in = 1'($urandom);
    tick();
    clear     = 1'b0;
    bit_valid = 1'b0;
    send_code(KEY, 1'b1);
    check_attempt(KEY);
  endtask

  task automatic test_reset_mid();
    logic [5:0] w;
    for (int i = 0; i < 3; i++) begin
      w = wrong_code();
      send_code(w, 1'b0);
      if (i < 2) check_attempt(w);
    end
    tick();
    tick();
    n_checks++;
    if (st() !== exp_st(0, 0, 1, 1, 0)) begin
      n_fail++;
      $display("FAIL pre_reset_lockout: status %b want %b", st(), exp_st(0, 0, 1, 1, 0));
    end
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_fails = 0;
    check_reset_values("reset_in_lockout");
    send_code(KEY, 1'b0);
    check_attempt(KEY);
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      bit_in    = 1'($urandom);
      tick();
    end
    bit_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_values("reset_mid_entry");
    send_code(KEY, 1'b0);
    check_attempt(KEY);
  endtask

  task automatic test_back_to_back();
    send_code(6'b000000, 1'b0);
    check_attempt(6'b000000);
    send_code(6'b111111, 1'b0);
    check_attempt(6'b111111);
    send_code(KEY, 1'b0);
    check_attempt(KEY);
  endtask

  task automatic test_random();
    logic [5:0] cd;
    for (int i = 0; i < 14; i++) begin
      cd = ($urandom_range(0, 2) == 0) ? KEY : 6'($urandom);
      send_code(cd, 1'b1);
      check_attempt(cd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_correct();
    test_lockout();
    test_single_mismatch();
    test_success_resets();
    test_clear();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lock_code_driver.md
# lock_code_driver

Serial code-entry front end that drives the combinational `encrypted_lock` checker.
- Accepts code bits one per handshake and assembles a 6-bit candidate code.
- Presents the code on lock inputs `a`..`f` and samples the lock verdict `z`.
- Reports unlock or failure, and enforces a retry limit with a timed lockout.
- Sits between the keypad/serial input logic and `encrypted_lock`; it is the initiator side of the lock's code/verdict interface.

## Interface
Parameters:
- `MAX_TRIES`, default 3: consecutive failed attempts that trigger lockout; legal range 1..3.
- `LOCKOUT_CYCLES`, default 16: length of the lockout period in cycles; must be ≥1.
- `HOLD_CYCLES`, default 4: length of the `unlocked` assertion in cycles; must be ≥1.

Ports:
- Single clock `clk`; reset `rst` is synchronous, active-high.
- `clk` — input, 1 bit: rising-edge clock.
- `rst` — input, 1 bit: synchronous active-high reset.
- `bit_in` — input, 1 bit: code bit, sent MSB first.
- `bit_valid` — input, 1 bit: `bit_in` is valid.
- `bit_ready` — output, 1 bit: block can accept a bit.
- `clear` — input, 1 bit: discard the partial entry.
- `a`, `b`, `c`, `d`, `e`, `f` — outputs, 1 bit each: code presented to the lock. `a` carries the first bit received, `f` the sixth.
- `z` — input, 1 bit: lock verdict, 1 means the code matches.
- `unlocked` — output, 1 bit: high for `HOLD_CYCLES` after a match.
- `fail` — output, 1 bit: one-cycle pulse after a mismatch.
- `locked_out` — output, 1 bit: high during the lockout period.
- `tries_left` — output, 2 bits: `MAX_TRIES` minus the current failure count.

## Operation
- States: COLLECT, PRESENT, CHECK, OPEN, LOCKOUT. All outputs are registered.
- **Reset:**
  - State goes to COLLECT; bit count, shift register, `a`..`f`, failure count, and hold/lockout timers are cleared.
  - Outputs after reset: `bit_ready`=1, `unlocked`=0, `fail`=0, `locked_out`=0, `tries_left`=`MAX_TRIES`.
- **COLLECT:**
  - `bit_ready`=1. A bit is accepted when `bit_valid` and `bit_ready` are both high.
  - Each accepted bit shifts into the shift register (new bit at the LSB) and increments the bit count (0..5).
  - Acceptance of the 6th bit moves to PRESENT and loads `a`..`f` from the shift register, first bit to `a`.
  - `clear` has priority over `bit_valid` in the same cycle: the bit is dropped, and the count and shift register go to 0.
  - `clear` is ignored in all other states.
- **PRESENT:** one settle cycle with `bit_ready`=0 and `a`..`f` stable; next state is CHECK.
- **CHECK:** samples `z` in this cycle.
  - `z`=1: go to OPEN, failure count goes to 0.
  - `z`=0, failure count +1 < `MAX_TRIES`: go to COLLECT, pulse `fail`, increment the failure count.
  - `z`=0, failure count +1 = `MAX_TRIES`: go to LOCKOUT, pulse `fail`, set `locked_out`.
- **OPEN:** `unlocked`=1 for exactly `HOLD_CYCLES` cycles, then go to COLLECT.
- **LOCKOUT:** `locked_out`=1 and `tries_left`=0 for exactly `LOCKOUT_CYCLES` cycles; then failure count goes to 0 and state goes to COLLECT.
- **Return to COLLECT (any path):** `a`..`f`, the shift register, and the bit count are all cleared to 0.
- `bit_ready`=0 in PRESENT, CHECK, OPEN, and LOCKOUT. `bit_valid` in those states is ignored and the bits are lost.
- `rst` asserted in any state, mid-entry or mid-lockout, aborts the current activity and restores the reset values on the next edge.

## Timing
- Let cycle T be the cycle in which the 6th bit is accepted.
- T+1: PRESENT; `a`..`f` hold the new code.
- T+2: CHECK; `z` is sampled.
- T+3, match: `unlocked`=1 from T+3 through T+2+`HOLD_CYCLES`; `bit_ready`=1 at T+3+`HOLD_CYCLES`.
- T+3, mismatch without lockout: `fail`=1 for that cycle only; `tries_left` already decremented; `bit_ready`=1.
- T+3, mismatch reaching the limit: `fail`=1 and `locked_out`=1; `locked_out` stays high through T+2+`LOCKOUT_CYCLES`; `bit_ready`=1 and `tries_left`=`MAX_TRIES` at T+3+`LOCKOUT_CYCLES`.
- Minimum accepted-bit-to-verdict latency is 3 cycles after the final bit.
- Back-to-back entries: the fastest full mismatch attempt takes 6+3 cycles.

## Test plan
Bench models the lock with key 101011 (`a`=1, `b`=0, `c`=1, `d`=0, `e`=1, `f`=1) and uses default parameters.
- **Correct entry:** send 1,0,1,0,1,1 with continuous valid.
  - `a`..`f`=101011 at T+1.
  - `unlocked`=1 for cycles T+3..T+6.
  - `tries_left`=3; `bit_ready` returns at T+7.
- **Single mismatch:** send 001010.
  - `fail` pulses once at T+3.
  - `tries_left`=2.
  - `a`..`f`=000000 and `bit_ready`=1 at T+3.
- **Lockout:** three consecutive wrong codes (001010, 101010, 011010).
  - The third produces `fail` and `locked_out` at T+3.
  - `locked_out` is held for 16 cycles; bits offered during that time are ignored.
  - After lockout, `tries_left`=3; a following correct code unlocks.
- **Clear mid-entry:** send 1,0,1, assert `clear` together with `bit_valid`, then send 101011.
  - Exactly one unlock, with no `fail`.
  - The bit offered with `clear` is not captured.
- **Success resets failures:** two wrong codes (`tries_left`=1), then 101011.
  - Unlock occurs.
  - `tries_left`=3 at T+3.
- **Reset mid-operation:** assert `rst` for 1 cycle during LOCKOUT, and separately after 4 accepted bits.
  - Next cycle shows all reset values.
  - A subsequent full correct entry unlocks.
